// File: rtl/lcd_responder.sv
// Display-side model of an HD44780-style 8-bit character LCD bus.
// Decodes falling-edge strobed transfers into DDRAM, cursor and mode registers,
// and holds a busy window after each accepted transfer.
module lcd_responder #(
    parameter int unsigned CMD_CYCLES   = 4,
    parameter int unsigned CLEAR_CYCLES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       entry_inc,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       overrun
);

    localparam int unsigned MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DEPTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state;
    logic             en_q;
    logic [7:0]       data_q;
    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       fill_idx;
    logic [7:0]       mem [DEPTH];

    logic fire_c;
    logic wr_req_c;
    logic last_edge_c;
    logic accept_c;
    logic is_clear_c;
    logic data_wr_c;
    logic fill_act_c;

    // Cursor advance on the two-line address map.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - 7'd1;
    endfunction

    // Transfer qualification; the final busy edge still accepts a new transfer.
    assign fire_c      = en_q && !lcd_enable;
    assign wr_req_c    = fire_c && !ctrl_q[1];
    assign last_edge_c = (state != ST_IDLE) && (cnt == CNT_W'(1));
    assign accept_c    = wr_req_c && ((state == ST_IDLE) || last_edge_c);
    assign is_clear_c  = !ctrl_q[0] && (data_q == 8'h01);
    assign data_wr_c   = accept_c && ctrl_q[0];
    assign fill_act_c  = (state == ST_CLEAR) && !fill_idx[7];

    // Input capture, FSM, busy countdown and register-file decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fill_idx    <= '0;
            en_q        <= 1'b0;
            data_q      <= '0;
            ctrl_q      <= '0;
            busy        <= 1'b0;
            cursor_addr <= '0;
            entry_inc   <= 1'b1;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            en_q   <= lcd_enable;
            data_q <= lcd_data;
            ctrl_q <= lcd_ctrl;

            if (wr_req_c && !accept_c) overrun <= 1'b1;
            if (fill_act_c) fill_idx <= fill_idx + 8'd1;

            case (state)
                ST_IDLE: ;
                default: begin
                    if (last_edge_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase

            if (accept_c) begin
                busy <= 1'b1;
                if (is_clear_c) begin
                    state    <= ST_CLEAR;
                    cnt      <= CNT_W'(CLEAR_CYCLES);
                    fill_idx <= '0;
                end else begin
                    state <= ST_EXEC;
                    cnt   <= CNT_W'(CMD_CYCLES);
                end

                if (ctrl_q[0]) begin
                    cursor_addr <= entry_inc ? addr_inc(cursor_addr) : addr_dec(cursor_addr);
                end else begin
                    casez (data_q)
                        8'b1???????: cursor_addr <= data_q[6:0];
                        8'b01??????: ;
                        8'b001?????: ;
                        8'b0001????: begin
                            if (!data_q[3])
                                cursor_addr <= data_q[2] ? addr_inc(cursor_addr) : addr_dec(cursor_addr);
                        end
                        8'b00001???: {display_on, cursor_on, blink_on} <= data_q[2:0];
                        8'b000001??: entry_inc <= data_q[1];
                        8'b0000001?: cursor_addr <= '0;
                        8'b00000001: begin
                            cursor_addr <= '0;
                            entry_inc   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // DDRAM writes: clear fill sweep and data writes at the cursor.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_act_c) mem[fill_idx[6:0]] <= 8'h20;
            if (data_wr_c)  mem[cursor_addr]   <= data_q;
        end
    end

    // Registered inspection read, returns the pre-write byte on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= 8'h00;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: directed scenarios plus random
// transfers checked against a transaction-level model of the display.
module tb_lcd_responder;

    localparam int CMD   = 4;
    localparam int CLR   = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lcd_data = 8'h00;
    logic [1:0] lcd_ctrl = 2'b00;
    logic       lcd_enable = 1'b0;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] cursor_addr;
    logic       entry_inc;
    logic       display_on;
    logic       cursor_on;
    logic       blink_on;
    logic       overrun;

    lcd_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR)) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_data    (lcd_data),
        .lcd_ctrl    (lcd_ctrl),
        .lcd_enable  (lcd_enable),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .cursor_addr (cursor_addr),
        .entry_inc   (entry_inc),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] ref_mem [128];
    bit         ref_valid [128];
    logic [6:0] ref_cur;
    bit         ref_inc, ref_d, ref_c, ref_b, ref_ovr;
    int         busy_end;
    bit         last_clear;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] step(input logic [6:0] a, input bit up);
        int v;
        v = int'(a);
        if (up) begin
            if (v == 39)       v = 64;
            else if (v == 103) v = 0;
            else               v = (v + 1) % 128;
        end else begin
            if (v == 0)        v = 103;
            else if (v == 64)  v = 39;
            else               v = (v + 127) % 128;
        end
        return 7'(v);
    endfunction

    task automatic model_xfer(input logic rs, input logic rw, input logic [7:0] d, input int e);
        int hb;
        if (rw) return;
        if (e < busy_end) begin
            ref_ovr = 1'b1;
            return;
        end
        busy_end   = e + CMD;
        last_clear = 1'b0;
        if (rs) begin
            ref_mem[ref_cur]   = d;
            ref_valid[ref_cur] = 1'b1;
            ref_cur = step(ref_cur, ref_inc);
            return;
        end
        hb = -1;
        for (int i = 0; i < 8; i++) if (d[i]) hb = i;
        case (hb)
            7: ref_cur = d[6:0];
            4: if (!d[3]) ref_cur = step(ref_cur, d[2]);
            3: begin ref_d = d[2]; ref_c = d[1]; ref_b = d[0]; end
            2: ref_inc = d[1];
            1: ref_cur = 7'h00;
            0: begin
                ref_cur = 7'h00;
                ref_inc = 1'b1;
                for (int i = 0; i < 128; i++) begin
                    ref_mem[i]   = 8'h20;
                    ref_valid[i] = 1'b1;
                end
                busy_end   = e + CLR;
                last_clear = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".busy"},    32'(busy),        32'(cyc < busy_end));
        chk({tag, ".cursor"},  32'(cursor_addr), 32'(ref_cur));
        chk({tag, ".inc"},     32'(entry_inc),   32'(ref_inc));
        chk({tag, ".disp"},    32'(display_on),  32'(ref_d));
        chk({tag, ".curs"},    32'(cursor_on),   32'(ref_c));
        chk({tag, ".blink"},   32'(blink_on),    32'(ref_b));
        chk({tag, ".overrun"}, 32'(overrun),     32'(ref_ovr));
    endtask

    // Caller sits at a negedge; returns at the negedge right after the firing edge.
    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input string tag);
        lcd_enable = 1'b1;
        lcd_data   = d;
        lcd_ctrl   = {rw, rs};
        @(negedge clk);
        lcd_enable = 1'b0;
        lcd_data   = 8'($urandom);
        @(negedge clk);
        model_xfer(rs, rw, d, cyc);
        check_state(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_state(tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        while (cyc < busy_end) begin
            @(negedge clk);
            check_state(tag);
        end
    endtask

    task automatic measure_busy(input int exp_len, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'(exp_len));
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset(input logic hold_en);
        rst        = 1'b1;
        lcd_enable = hold_en;
        lcd_data   = 8'h90;
        lcd_ctrl   = 2'b00;
        @(negedge clk);
        if (last_clear && cyc <= busy_end)
            for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
        ref_cur = 7'h00; ref_inc = 1'b1;
        ref_d = 1'b0; ref_c = 1'b0; ref_b = 1'b0; ref_ovr = 1'b0;
        busy_end = 0; last_clear = 1'b0;
        check_state("rst");
        chk("rst.rd_data", 32'(rd_data), 32'h0);
        rst        = 1'b0;
        lcd_enable = 1'b0;
    endtask

    function automatic logic [7:0] rand_instr();
        int cls;
        logic [7:0] base;
        cls = $urandom_range(0, 8);
        if (cls == 7 && $urandom_range(0, 2) != 0) cls = 3;
        if (cls == 8) return 8'h00;
        base = 8'h80 >> cls;
        return base | (8'($urandom) & (base - 8'd1));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rs, rw;
        logic [7:0] d;
        logic [6:0] a;
        int         gap;

        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 8'h00;
            ref_valid[i] = 1'b0;
        end
        last_clear = 1'b0;
        busy_end = 0;

        do_reset(1'b0);

        // Data write, busy length, registered read
        xfer(1'b1, 1'b0, 8'h48, "w48");
        measure_busy(CMD, "w48.busy_len");
        chk("w48.cursor", 32'(cursor_addr), 32'h1);
        rd_check(7'h00, 8'h48, "w48.rd");

        // Line wrap on increment, then decrement wrap
        xfer(1'b0, 1'b0, 8'hA7, "setA7");    wait_idle("setA7");
        xfer(1'b1, 1'b0, 8'h41, "w41");      wait_idle("w41");
        chk("w41.cursor", 32'(cursor_addr), 32'h40);
        rd_check(7'h27, 8'h41, "w41.rd");
        xfer(1'b0, 1'b0, 8'h04, "entry_dec"); wait_idle("entry_dec");
        xfer(1'b0, 1'b0, 8'h80, "set00");     wait_idle("set00");
        xfer(1'b1, 1'b0, 8'h42, "w42");       wait_idle("w42");
        chk("w42.cursor", 32'(cursor_addr), 32'h67);
        rd_check(7'h00, 8'h42, "w42.rd");

        // Random writes then clear
        repeat (6) begin
            xfer(1'b1, 1'b0, 8'($urandom), "prew");
            wait_idle("prew");
        end
        xfer(1'b0, 1'b0, 8'h01, "clear");
        measure_busy(CLR, "clear.busy_len");
        check_state("clear.done");
        chk("clear.cursor", 32'(cursor_addr), 32'h0);
        chk("clear.inc", 32'(entry_inc), 32'h1);
        for (int i = 0; i < 128; i++) rd_check(7'(i), 8'h20, "clear.rd");

        // Transfer two cycles after an accepted one is dropped
        xfer(1'b1, 1'b0, 8'h11, "ovr.first");
        xfer(1'b1, 1'b0, 8'h22, "ovr.second");
        chk("ovr.flag", 32'(overrun), 32'h1);
        wait_idle("ovr");
        chk("ovr.cursor", 32'(cursor_addr), 32'h1);
        rd_check(7'h00, 8'h11, "ovr.rd0");
        rd_check(7'h01, 8'h20, "ovr.rd1");
        idle(3, "ovr.sticky");
        chk("ovr.sticky", 32'(overrun), 32'h1);

        // Display control and ignored read transfer
        xfer(1'b0, 1'b0, 8'h0F, "disp0F"); wait_idle("disp0F");
        chk("disp0F.bits", 32'({display_on, cursor_on, blink_on}), 32'h7);
        xfer(1'b0, 1'b0, 8'h08, "disp08"); wait_idle("disp08");
        chk("disp08.bits", 32'({display_on, cursor_on, blink_on}), 32'h0);
        xfer(1'b0, 1'b1, 8'h0F, "rw");
        chk("rw.busy", 32'(busy), 32'h0);
        chk("rw.bits", 32'({display_on, cursor_on, blink_on}), 32'h0);
        idle(2, "rw");

        // Enable held high: no transfer until it falls, last byte used
        lcd_enable = 1'b1; lcd_data = 8'h90; lcd_ctrl = 2'b00;
        idle(4, "hold");
        lcd_data = 8'h85;
        @(negedge clk);
        lcd_enable = 1'b0;
        @(negedge clk);
        model_xfer(1'b0, 1'b0, 8'h85, cyc);
        check_state("hold.fall");
        chk("hold.cursor", 32'(cursor_addr), 32'h05);
        wait_idle("hold");

        // Reset mid-clear with enable held high through reset
        do_reset(1'b0);
        xfer(1'b0, 1'b0, 8'h01, "clr2");
        idle(39, "clr2");
        do_reset(1'b1);
        chk("midrst.busy", 32'(busy), 32'h0);
        chk("midrst.cursor", 32'(cursor_addr), 32'h0);
        idle(3, "post_rst");
        xfer(1'b1, 1'b0, 8'h55, "w55"); wait_idle("w55");
        chk("w55.cursor", 32'(cursor_addr), 32'h1);
        rd_check(7'h00, 8'h55, "w55.rd");

        // Random transfers against the model
        xfer(1'b0, 1'b0, 8'h01, "rclr"); wait_idle("rclr");
        for (int t = 0; t < 80; t++) begin
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 9) == 0);
            d  = rs ? 8'($urandom) : rand_instr();
            xfer(rs, rw, d, "rnd");
            gap = $urandom_range(0, 4);
            idle(gap, "rnd.gap");
            if (cyc >= busy_end) begin
                a = 7'($urandom);
                if (ref_valid[a]) rd_check(a, ref_mem[a], "rnd.rd");
            end
        end
        wait_idle("rnd.end");
        for (int i = 0; i < 128; i += 9)
            if (ref_valid[i]) rd_check(7'(i), ref_mem[i], "rnd.final_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Behavioural responder for the 8-bit parallel character-LCD bus (lcd_data / lcd_ctrl / lcd_enable) driven by the memory-mapped LCD port. It decodes the HD44780-style instruction and data writes into an internal 128-byte DDRAM, a cursor, and mode registers, and enforces a busy window after each accepted transfer. It serves as the display-side end of the link for simulation and on-chip self-check, and exposes a read port so benches can inspect screen contents.

## Interface

- CMD_CYCLES, 4: busy duration in clk cycles after any accepted transfer except clear; must be ≥1.
- CLEAR_CYCLES, 128: busy duration after clear display; must be ≥128.
- clk  input  1  system clock; one clock domain, rising edge.
- rst  input  1  synchronous, active-high reset.
- lcd_data  input  8  bus data byte.
- lcd_ctrl  input  2  bit0 = RS (0 instruction, 1 data); bit1 = RW (1 read).
- lcd_enable  input  1  strobe; transfer latched on its falling edge.
- rd_addr  input  7  DDRAM inspection address.
- rd_data  output  8  DDRAM[rd_addr], registered.
- busy  output  1  executing; new transfers are dropped.
- cursor_addr  output  7  current DDRAM address counter.
- entry_inc  output  1  1 = increment after data write, 0 = decrement.
- display_on, cursor_on, blink_on  output  1 each  display-control bits.
- overrun  output  1  sticky: a transfer arrived while busy.

## Operation

- Input register stage: en_q, data_q, ctrl_q are loaded from the inputs every clk.
- Transfer fires on an edge where lcd_enable = 0 and en_q = 1; it uses data_q/ctrl_q, the values from the last edge at which enable was high.
- RW = 1 transfers: ignored entirely. No busy, no overrun, no state change.
- Transfer while busy: dropped; overrun ← 1 until rst.
- FSM states:
  - IDLE: accepts transfers. Accepted clear → CLEAR; any other accepted transfer → EXEC.
  - EXEC: countdown of CMD_CYCLES, then → IDLE.
  - CLEAR: writes 0x20 to addresses 0..127, one per cycle, then holds busy until CLEAR_CYCLES elapse, then → IDLE.
- Data write (RS=1): DDRAM[cursor_addr] ← data, then cursor advances per entry_inc.
- Instruction decode (RS=0), priority on the highest set bit:
  - 1xxxxxxx: cursor_addr ← data[6:0].
  - 01xxxxxx: CGRAM address; accepted and busy, no state change.
  - 001xxxxx: function set; accepted, no state change.
  - 0001 S/C R/L xx: S/C=1 no state change; S/C=0 moves the cursor (R/L=1 increment rules, 0 decrement rules).
  - 00001DCB: display_on ← D, cursor_on ← C, blink_on ← B.
  - 000001 I/D S: entry_inc ← I/D; S ignored.
  - 0000001x: cursor_addr ← 0.
  - 00000001: clear. cursor_addr ← 0, entry_inc ← 1.
  - 0x00: accepted, no state change, busy CMD_CYCLES.
- Cursor wrap, two-line map:
  - Increment: 0x27 → 0x40, 0x67 → 0x00, otherwise +1 mod 128.
  - Decrement: 0x00 → 0x67, 0x40 → 0x27, otherwise −1 mod 128.
- DDRAM is never touched by rst. Contents are unknown until the first clear.

## Timing

- Reset values: busy 0, cursor_addr 0, entry_inc 1, display_on/cursor_on/blink_on 0, overrun 0, rd_data 0x00, FSM IDLE, en_q 0.
- Enable sampled low at edge E (transfer fires) → DDRAM, cursor, and mode regs updated at E; busy = 1 from E.
- Busy length, counted from E: CMD_CYCLES edges for normal transfers, CLEAR_CYCLES edges for clear. Busy is 0 after the final edge, and a transfer fired on that same final edge is accepted.
- rd_data is a 1-cycle registered read with read-before-write: same-edge write and read of one address returns the old byte.
- During CLEAR, rd_data of a location reflects 0x20 starting the edge after that location is filled.
- rst mid-operation: aborts EXEC/CLEAR, and all outputs take reset values on the next edge. A partial clear leaves DDRAM partially filled. The first transfer is accepted only after a fresh high→low enable following rst deassert.
- lcd_enable held high: no transfer. Only a falling edge fires, never a level.

## Test plan

- Reset, then data write 0x48 (RS=1) → DDRAM[0]=0x48 (rd_addr 0 gives 0x48 one cycle later), cursor_addr 1, busy high exactly 4 cycles.
- Instruction 0xA7, then data 0x41 → DDRAM[0x27]=0x41, cursor_addr 0x40. Then 0x04 and 0x80, then data 0x42 → DDRAM[0]=0x42, cursor_addr 0x67.
- Instruction 0x01 after random writes → busy 128 cycles, all 128 locations read 0x20, cursor_addr 0, entry_inc 1.
- Second transfer fired 2 cycles after the first → dropped (DDRAM/cursor unchanged by it), overrun=1 until rst.
- 0x0F → display_on, cursor_on, blink_on = 1. Then 0x08 → all 0. RW=1 transfer with 0x0F → no change, busy stays 0.
- rst asserted 40 cycles into a clear → next edge busy 0, cursor_addr 0. After rst deassert, data 0x55 → DDRAM[0]=0x55, cursor_addr 1.
